// File: rtl/conv_max_pool.sv
// ---------------------------------------------------------------------------
// conv_max_pool
//
// Purpose:
//   2x2 / stride-2 max pooling applied to a stream of post-ReLU convolution
//   samples. Samples arrive in raster order, one channel map at a time. The
//   map width (24, 10 or 5) is taken from layer_num on the first sample of
//   each map. Each pooled value is produced on the odd column of an odd row,
//   after the other three samples of its window have been seen.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   layer_num  in   [1:0] map width select: 0->24, 1->10, 2->5, 3->24
//   in_valid   in   a conv sample is present on in_data
//   in_ready   out  the block accepts the sample this cycle
//   in_data    in   [DATA_W-1:0] unsigned conv sample after ReLU
//   out_valid  out  out_data holds a pooled value
//   out_ready  in   the consumer takes out_data this cycle
//   out_data   out  [DATA_W-1:0] max of one 2x2 pooling window
//   out_last   out  marks the final pooled value of a map
//   busy       out  a map is partially received
// ---------------------------------------------------------------------------
module conv_max_pool #(
  parameter int DATA_W = 21,
  parameter int MAX_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        layer_num,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  // Counters and the latched width share one width so they compare directly.
  localparam int CNT_W    = $clog2(MAX_W + 1);
  localparam int LB_DEPTH = MAX_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] data_t;

  // Map width selected by the layer code; the reserved code behaves as 0.
  function automatic cnt_t layerWidth(input logic [1:0] layer);
    case (layer)
      2'd1:    return cnt_t'(10);
      2'd2:    return cnt_t'(5);
      default: return cnt_t'(24);
    endcase
  endfunction

  // Unsigned maximum; on a tie either operand gives the same value.
  function automatic data_t maxOf(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

  cnt_t  row_q, row_d;
  cnt_t  col_q, col_d;
  cnt_t  width_q, width_d;
  data_t hold_q, hold_d;
  logic  outValid_q, outValid_d;
  logic  outLast_q, outLast_d;
  data_t outData_q, outData_d;

  // Line buffer holding the top-row maximum of each window column pair.
  data_t lineBuf [LB_DEPTH];
  logic  lbWe;
  data_t lbWdata;
  logic [LB_AW-1:0] lbIdx;
  data_t lbRdata;

  logic  accept;
  logic  firstSample;
  cnt_t  curWidth;
  logic  widthOdd;
  cnt_t  lastIdx;
  cnt_t  lastPair;
  logic  discard;

  // Only one output register exists, so input is stalled whenever a pooled
  // value is pending and the consumer is not taking it this cycle.
  assign in_ready = !(outValid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  // The first sample of a map uses layer_num directly; every later sample
  // uses the width latched on that first sample, so mid-map layer changes
  // have no effect.
  assign firstSample = (row_q == '0) && (col_q == '0);
  assign curWidth    = firstSample ? layerWidth(layer_num) : width_q;
  assign widthOdd    = curWidth[0];
  assign lastIdx     = curWidth - cnt_t'(1);
  assign lastPair    = lastIdx - cnt_t'(widthOdd);

  // On odd widths the trailing column and row have no partner and are
  // dropped without touching any state other than the counters.
  assign discard = widthOdd && ((col_q == lastIdx) || (row_q == lastIdx));

  // Column pair index; for every kept odd column it stays below MAX_W/2.
  assign lbIdx   = LB_AW'(col_q >> 1);
  assign lbRdata = lineBuf[lbIdx];

  // Next-state logic: counters, hold register, line buffer write and the
  // output register. An output transfer clears out_valid, but a window
  // completed on the same edge reloads it.
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    width_d    = width_q;
    hold_d     = hold_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    outData_d  = outData_q;
    lbWe       = 1'b0;
    lbWdata    = '0;

    if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end

    if (accept) begin
      if (firstSample) begin
        width_d = curWidth;
      end

      if (!discard) begin
        if (!col_q[0]) begin
          hold_d = in_data;
        end else if (!row_q[0]) begin
          lbWe    = 1'b1;
          lbWdata = maxOf(hold_q, in_data);
        end else begin
          outValid_d = 1'b1;
          outData_d  = maxOf(lbRdata, maxOf(hold_q, in_data));
          outLast_d  = (row_q == lastPair) && (col_q == lastPair);
        end
      end

      if (col_q == lastIdx) begin
        col_d = '0;
        row_d = (row_q == lastIdx) ? '0 : row_q + cnt_t'(1);
      end else begin
        col_d = col_q + cnt_t'(1);
      end
    end
  end

  // State registers; reset abandons any partial map and pending output.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      width_q    <= cnt_t'(24);
      hold_q     <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outData_q  <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      width_q    <= width_d;
      hold_q     <= hold_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      outData_q  <= outData_d;
    end
  end

  // Line buffer storage; no reset needed since each entry is written on an
  // even row before the odd row below reads it.
  always_ff @(posedge clk) begin
    if (lbWe) begin
      lineBuf[lbIdx] <= lbWdata;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign busy      = (row_q != '0) || (col_q != '0);

endmodule

// File: doc/conv_max_pool.md
CONV_MAX_POOL -- requirements
Module: conv_max_pool

Interface
REQ-001 The block SHALL have parameter DATA_W, default 21, giving the width of conv/ReLU result samples.
REQ-002 The block SHALL have parameter MAX_W, default 24, giving the largest conv map row width and sizing the line buffer to MAX_W/2 entries.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: sole clock, rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port layer_num, input, 2 bits: layer select; 0 selects a 24-wide map, 1 a 10-wide map, 2 a 5-wide map, and 3 is reserved and treated as 0.
REQ-007 Port in_valid, input, 1 bit: a conv sample is present.
REQ-008 Port in_ready, output, 1 bit: the block accepts the sample this cycle.
REQ-009 Port in_data, input, DATA_W bits: unsigned conv sample after ReLU, in raster order within one channel map.
REQ-010 Port out_valid, output, 1 bit: out_data holds a pooled value.
REQ-011 Port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-012 Port out_data, output, DATA_W bits: 2x2 max of one pooling window.
REQ-013 Port out_last, output, 1 bit: qualifies the final pooled value of a map.
REQ-014 Port busy, output, 1 bit: high while a map is partially received.

Function
REQ-015 A sample SHALL transfer on any rising edge where in_valid and in_ready are both 1; an output SHALL transfer on any rising edge where out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal NOT(out_valid AND NOT out_ready), so only a single output register is held.
REQ-017 Map width W SHALL be latched from layer_num on the first accepted sample of a map (row=0, col=0); layer_num changes during a map SHALL be ignored.
REQ-018 The block SHALL keep counters col in 0..W-1 and row in 0..W-1 that advance on each accepted sample; col wraps to 0 and row increments; after (W-1, W-1) both wrap to 0.
REQ-019 Sample at even col, col < W-1 or W even: the block SHALL store it in hold register h.
REQ-020 Sample at odd col on an even row: the block SHALL write linebuf[col>>1] = max(h, sample).
REQ-021 Sample at odd col on an odd row: the block SHALL load out_data = max(linebuf[col>>1], h, sample), set out_valid on the next edge (1-cycle latency), and set out_last if row = W-1-(W mod 2) and col = W-1-(W mod 2).
REQ-022 When W is odd, samples at col = W-1 or row = W-1 SHALL be accepted and discarded, producing no output.
REQ-023 Each map SHALL yield exactly floor(W/2)^2 outputs: 144 for layer 0, 25 for layer 1, and 4 for layer 2.
REQ-024 All comparisons SHALL be unsigned over DATA_W bits; on a tie either operand may be selected, since the result value is identical.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable and no sample SHALL be accepted.
REQ-026 out_valid SHALL clear after the transfer unless a new output is loaded on the same edge.
REQ-027 busy SHALL be 1 when (row, col) is not (0, 0), and 0 otherwise.
REQ-028 Back-to-back maps SHALL stream with no idle cycle required between them.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL clear out_valid, out_last, out_data, row, col, h, and busy, and set W to 24.
REQ-030 in_ready SHALL be 1 in the cycle after reset.
REQ-031 linebuf contents need not be cleared, because every entry is written before it is read.
REQ-032 A reset asserted mid-map SHALL abandon the partial map, discard any pending output, and restart at row 0, col 0.

Verification
REQ-033 Layer 0, in_data = row*24+col, out_ready=1 -> 144 outputs with out[r][c] = (2r+1)*24+2c+1; the first output is 25 and the last is 575 with out_last=1.
REQ-034 Layer 2, in_data = 0..24 -> exactly 4 outputs: 6, 8, 16, 18; out_last=1 on 18; column 4 and row 4 produce no output.
REQ-035 Layer 0, out_ready held 0 for 5 cycles with an output pending -> in_ready=0 and out_data stable for those 5 cycles, with no sample lost or duplicated over the full map.
REQ-036 Window values {3, 7, 0x1FFFFF, 5} placed in each of the 4 positions in turn -> out_data = 0x1FFFFF each time; an all-zero window -> 0.
REQ-037 Layer 0, 30 samples accepted, then rst for 1 cycle -> out_valid=0 and busy=0; a following full map matches the expected results of REQ-033.
REQ-038 A layer 0 map followed immediately by a layer 1 map (100 samples, layer_num switched mid-first-map) -> 144 outputs then 25 outputs, each map ending with out_last=1.
